// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master single-word memory bus controller with configurable wait states.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise m1 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              win;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] m0_rd_q;
    logic [DATA_W-1:0] m1_rd_q;
    logic              grant;
    logic              in_acc;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;
    // last holds the most recent winner; on a tie the other port goes next
    assign grant = (m0_req && m1_req) ? !last : m1_req;
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (state == IDLE && (m0_req || m1_req))
            last <= grant;
    end
`else
    assign grant = m1_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_rd_q   <= '0;
            m1_rd_q   <= '0;
        end else begin
            case (state)
                IDLE: if (m0_req || m1_req) begin
                    state     <= ACCESS;
                    cnt       <= 4'(WAIT_CYCLES);
                    win       <= grant;
                    lat_we    <= grant ? m1_we : m0_we;
                    lat_addr  <= grant ? m1_addr : m0_addr;
                    lat_wdata <= grant ? m1_wdata : m0_wdata;
                end
                ACCESS: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state <= RESP;
                    if (!lat_we && !win) m0_rd_q <= mem_rdata;
                    if (!lat_we && win)  m1_rd_q <= mem_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_acc    = state == ACCESS;
    assign mem_rd    = in_acc && !lat_we;
    assign mem_wr    = in_acc && lat_we;
    assign mem_addr  = in_acc ? lat_addr : '0;
    assign mem_wdata = in_acc ? lat_wdata : '0;
    assign m0_ack    = state == RESP && !win;
    assign m1_ack    = state == RESP && win;
    assign m0_rdata  = m0_rd_q;
    assign m1_rdata  = m1_rd_q;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench over three arbiters with WAIT_CYCLES 1, 0 and 3.
module tb_mem_arbiter;
    logic        clk = 0;
    logic        rst_n [3];
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack [3], m1_ack [3], mem_rd [3], mem_wr [3], busy [3];
    logic [31:0] m0_rdata [3], m1_rdata [3], mem_addr [3], mem_wdata [3], mem_rdata [3];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] slv(input logic [31:0] a);
        return a == 32'h2 ? 32'h5A : a + 32'h1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        assign mem_rdata[g] = slv(mem_addr[g]);
        mem_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
            .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) rst_n[i] = 0;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
        step; step;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy[i], mem_rd[i], mem_wr[i], m0_ack[i], m1_ack[i]} !== 5'b0) begin
                errors++; $display("FAIL reset_ctrl[%0d] got=%b exp=00000", i, {busy[i], mem_rd[i], mem_wr[i], m0_ack[i], m1_ack[i]});
            end
            checks++;
            if ({mem_addr[i], mem_wdata[i], m0_rdata[i], m1_rdata[i]} !== 128'h0) begin
                errors++; $display("FAIL reset_data[%0d] got=%h exp=0", i, {mem_addr[i], mem_wdata[i], m0_rdata[i], m1_rdata[i]});
            end
        end
    endtask

    task automatic test_single_read;
        rst_n[0] = 1; step;
        m0_req = 1; m0_we = 0; m0_addr = 32'h2;
        step;
        checks++;
        if ({mem_rd[0], mem_wr[0], m0_ack[0]} !== 3'b100 || mem_addr[0] !== 32'h2) begin
            errors++; $display("FAIL read_c1 got=%b/%h exp=100/2", {mem_rd[0], mem_wr[0], m0_ack[0]}, mem_addr[0]);
        end
        step;
        checks++;
        if ({mem_rd[0], m0_ack[0]} !== 2'b10) begin
            errors++; $display("FAIL read_c2 got=%b exp=10", {mem_rd[0], m0_ack[0]});
        end
        step;
        checks++;
        if ({mem_rd[0], m0_ack[0], m1_ack[0], busy[0]} !== 4'b0101 || m0_rdata[0] !== 32'h5A) begin
            errors++; $display("FAIL read_c3 got=%b/%h exp=0101/5a", {mem_rd[0], m0_ack[0], m1_ack[0], busy[0]}, m0_rdata[0]);
        end
        m0_req = 0; step;
        checks++;
        if ({m0_ack[0], busy[0]} !== 2'b00) begin
            errors++; $display("FAIL read_c4 got=%b exp=00", {m0_ack[0], busy[0]});
        end
    endtask

    task automatic test_single_write;
        m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'hAA;
        for (int c = 1; c <= 2; c++) begin
            step;
            checks++;
            if ({mem_wr[0], mem_rd[0], m1_ack[0]} !== 3'b100 || mem_addr[0] !== 32'h80 || mem_wdata[0] !== 32'hAA) begin
                errors++; $display("FAIL write_c%0d got=%b/%h/%h exp=100/80/aa", c, {mem_wr[0], mem_rd[0], m1_ack[0]}, mem_addr[0], mem_wdata[0]);
            end
        end
        step;
        checks++;
        if ({mem_wr[0], m1_ack[0], m0_ack[0]} !== 3'b010 || m1_rdata[0] !== 32'h0 || mem_addr[0] !== 32'h0) begin
            errors++; $display("FAIL write_c3 got=%b/%h/%h exp=010/0/0", {mem_wr[0], m1_ack[0], m0_ack[0]}, m1_rdata[0], mem_addr[0]);
        end
        m1_req = 0; m1_we = 0; step;
    endtask

    task automatic test_mid_change;
        m0_req = 1; m0_we = 0; m0_addr = 32'h2;
        step;
        m0_addr = 32'h7;
        step;
        checks++;
        if (mem_addr[0] !== 32'h2) begin
            errors++; $display("FAIL midchg_addr got=%h exp=2", mem_addr[0]);
        end
        step;
        checks++;
        if (m0_ack[0] !== 1'b1 || m0_rdata[0] !== 32'h5A) begin
            errors++; $display("FAIL midchg_rdata got=%b/%h exp=1/5a", m0_ack[0], m0_rdata[0]);
        end
        m0_req = 0; step;
    endtask

    task automatic test_contention;
        logic exp_win [3];
        logic won;
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        exp_win = '{1'b0, 1'b1, 1'b0};
`else
        exp_win = '{1'b1, 1'b1, 1'b1};
`endif
        rst_n[0] = 0; step; rst_n[0] = 1; step;
        for (int r = 0; r < 3; r++) begin
            m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; m0_addr = 32'h10; m1_addr = 32'h20;
            n = 0;
            do begin step; n++; end while (!m0_ack[0] && !m1_ack[0] && n < 10);
            won = m1_ack[0];
            checks++;
            if (won !== exp_win[r] || n != 3 || (m0_ack[0] && m1_ack[0])) begin
                errors++; $display("FAIL contend_r%0d got=m%0d@%0d exp=m%0d@3", r, won, n, exp_win[r]);
            end
            checks++;
            if ((exp_win[r] ? m1_rdata[0] : m0_rdata[0]) !== (exp_win[r] ? 32'h21 : 32'h11)) begin
                errors++; $display("FAIL contend_rdata_r%0d got=%h exp=%h", r, exp_win[r] ? m1_rdata[0] : m0_rdata[0], exp_win[r] ? 32'h21 : 32'h11);
            end
            m0_req = 0; m1_req = 0; step;
        end
    endtask

    task automatic test_zero_wait;
        rst_n[0] = 0; rst_n[1] = 1; step;
        m0_req = 1; m0_we = 0; m0_addr = 32'h4;
        step;
        checks++;
        if ({mem_rd[1], m0_ack[1]} !== 2'b10 || mem_addr[1] !== 32'h4) begin
            errors++; $display("FAIL zw_c1 got=%b/%h exp=10/4", {mem_rd[1], m0_ack[1]}, mem_addr[1]);
        end
        step;
        checks++;
        if ({mem_rd[1], m0_ack[1]} !== 2'b01 || m0_rdata[1] !== 32'h5) begin
            errors++; $display("FAIL zw_c2 got=%b/%h exp=01/5", {mem_rd[1], m0_ack[1]}, m0_rdata[1]);
        end
        m0_addr = 32'h5;
        step;
        checks++;
        if ({m0_ack[1], busy[1]} !== 2'b00) begin
            errors++; $display("FAIL zw_c3 got=%b exp=00", {m0_ack[1], busy[1]});
        end
        step;
        checks++;
        if ({mem_rd[1], m0_ack[1]} !== 2'b10 || mem_addr[1] !== 32'h5) begin
            errors++; $display("FAIL zw_c4 got=%b/%h exp=10/5", {mem_rd[1], m0_ack[1]}, mem_addr[1]);
        end
        step;
        checks++;
        if (m0_ack[1] !== 1'b1 || m0_rdata[1] !== 32'h6) begin
            errors++; $display("FAIL zw_c5 got=%b/%h exp=1/6", m0_ack[1], m0_rdata[1]);
        end
        m0_req = 0; step;
    endtask

    task automatic test_reset_mid;
        int n;
        logic seen;
        rst_n[1] = 0; rst_n[2] = 1; step;
        m0_req = 1; m0_we = 0; m0_addr = 32'h9;
        step; step;
        checks++;
        if (mem_rd[2] !== 1'b1) begin
            errors++; $display("FAIL rstmid_access got=%b exp=1", mem_rd[2]);
        end
        rst_n[2] = 0; m0_req = 0;
        step;
        checks++;
        if ({busy[2], mem_rd[2], mem_wr[2], m0_ack[2], m1_ack[2]} !== 5'b0 || mem_addr[2] !== 32'h0 || m0_rdata[2] !== 32'h0) begin
            errors++; $display("FAIL rstmid_outs got=%b/%h/%h exp=00000/0/0", {busy[2], mem_rd[2], mem_wr[2], m0_ack[2], m1_ack[2]}, mem_addr[2], m0_rdata[2]);
        end
        rst_n[2] = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin step; seen |= m0_ack[2] | m1_ack[2]; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rstmid_noack got=%b exp=0", seen);
        end
        m0_req = 1; m0_addr = 32'h3;
        n = 0;
        do begin step; n++; end while (!m0_ack[2] && n < 12);
        checks++;
        if (m0_ack[2] !== 1'b1 || n != 5 || m0_rdata[2] !== 32'h4) begin
            errors++; $display("FAIL rstmid_reread got=%b@%0d/%h exp=1@5/4", m0_ack[2], n, m0_rdata[2]);
        end
        m0_req = 0; step;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_single_write;
        test_mid_change;
        test_contention;
        test_zero_wait;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory bus controller that shares the single-word memory bus (ROM/RAM read and write strobes, address, data) between the instruction-fetch port (m0) and the load/store port (m1) of the core. It accepts one request at a time, drives the shared bus for a configurable number of wait cycles, captures read data and returns a one-cycle acknowledge to the winning master. It sits between the core's fetch/LSU and the memory-mapped slaves; no slave is ever driven by more than one master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 1, extra cycles the strobe is held beyond the first (legal 0..15)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- m0_req / m1_req  input  1  request, held high until ack
- m0_we / m1_we  input  1  1 = write, 0 = read; valid while req
- m0_addr / m1_addr  input  ADDR_W  word address; valid while req
- m0_wdata / m1_wdata  input  DATA_W  write data; valid while req and we
- m0_ack / m1_ack  output  1  one-cycle completion pulse
- m0_rdata / m1_rdata  output  DATA_W  read data, valid in ack cycle, held until next completion for that port
- mem_rd  output  1  shared-bus read strobe
- mem_wr  output  1  shared-bus write strobe
- mem_addr  output  ADDR_W  shared-bus address
- mem_wdata  output  DATA_W  shared-bus write data
- mem_rdata  input  DATA_W  shared-bus read data (slave drives while mem_rd)
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req, arbitrate (see Configuration), latch winner id, we, addr, wdata into registers, load wait counter with WAIT_CYCLES, go ACCESS. No req: stay.
- ACCESS: mem_addr/mem_wdata from latched registers; mem_rd = !we, mem_wr = we. Counter nonzero: decrement, stay. Counter zero: on read capture mem_rdata into winner's rdata register; go RESP.
- RESP: strobes low; pulse winner's ack; go IDLE.
- Requests arriving or changing during ACCESS/RESP are ignored until IDLE; the latched transaction is not affected.
- Master dropping req mid-transaction: transaction still completes and acks (protocol violation, defined result).
- Write transactions leave the port's rdata register unchanged.
- mem_addr and mem_wdata drive 0 whenever state is not ACCESS; mem_rd and mem_wr are never high simultaneously.

## Timing
- Reset (rst_n low at a rising edge): next cycle state IDLE, mem_rd/mem_wr/acks/busy = 0, mem_addr/mem_wdata = 0, m0_rdata/m1_rdata = 0, RR pointer = m1. In-flight transaction is dropped with no ack.
- Latency: req sampled in IDLE at cycle 0 → strobe high cycles 1..WAIT_CYCLES+1 → ack in cycle WAIT_CYCLES+2.
- WAIT_CYCLES = 0: strobe high exactly one cycle; ack at cycle 2.
- Master deasserts req in the cycle after ack; a master holding req through ack is re-served as a new transaction from the following IDLE cycle.
- Throughput: one transaction per WAIT_CYCLES+3 cycles; IDLE always lasts at least one cycle between transactions.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin; on simultaneous requests the port not granted last wins; pointer updates on every grant; after reset m0 wins the first tie.
- Not defined: fixed priority, m1 (load/store) always wins ties; no pointer register.

## Test plan
- Single read: WAIT_CYCLES=1, m0 reads addr 0x2, slave returns 0x0000005A → mem_rd high cycles 1-2, m0_ack pulse cycle 3, m0_rdata = 0x0000005A, m1_ack stays 0.
- Single write: m1 writes 0x000000AA to addr 0x80 → mem_wr high with mem_addr 0x80, mem_wdata 0xAA for WAIT_CYCLES+1 cycles; m1_ack once; m1_rdata unchanged.
- Contention: m0 and m1 request together three consecutive times → with ARB_ROUND_ROBIN_EN grants m0, m1, m0; without, m1, m1, m1 while m0 waits.
- Zero wait: WAIT_CYCLES=0, back-to-back m0 reads of 0x4 and 0x5 with req held → acks in cycles 2 and 5, rdata 0x5 then 0x6.
- Reset mid-access: rst_n low during ACCESS of a WAIT_CYCLES=3 read → next cycle all outputs 0, no ack ever issued; subsequent m0 read of 0x3 returns 0x4 normally.
- Mid-transaction change: m0 changes addr from 0x2 to 0x7 during ACCESS → mem_addr stays 0x2, m0_rdata = 0x5A.
